// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared constants and types for the N-master bus arbiter:
//     - default bus width
//     - bus direction encodings (READ / WRITE)
//     - funct3 transfer size codes (SB/SH/SW/LBU/LHU)
//     - transfer FSM state type
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int XLEN_DEF = 32;

    // Bus direction as carried on i_wr_rd / o_wr_rd
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // funct3 size codes
    localparam logic [2:0] SZ_SB  = 3'b000;
    localparam logic [2:0] SZ_SH  = 3'b001;
    localparam logic [2:0] SZ_SW  = 3'b010;
    localparam logic [2:0] SZ_LBU = 3'b100;
    localparam logic [2:0] SZ_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Request selector for the bus arbiter. Produces a combinational one-hot
//   grant from the request vector; in round-robin mode the search starts at an
//   internal pointer which advances past the winner whenever i_en is high.
//   In fixed-priority mode the search always starts at index 0.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset (pointer -> 0)
//   i_req[N]      request vector
//   i_en          commit the current grant (advances the rr pointer)
//   o_grant[N]    one-hot grant, all zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N        = 2,
    parameter int ARB_MODE = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] start_s;
    logic [PW-1:0] win_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Search origin: the rr pointer in round-robin mode, index 0 otherwise
    always_comb begin
        if (ARB_MODE == 1) begin
            start_s = ptr_q;
        end else begin
            start_s = {PW{1'b0}};
        end
    end

    // Walk the requests from the origin, wrapping modulo N; first hit wins
    always_comb begin
        o_grant = {N{1'b0}};
        win_s   = start_s;
        found_s = 1'b0;
        idx_s   = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx_s = PW'((int'(start_s) + i) % N);
            if (!found_s && i_req[idx_s]) begin
                found_s        = 1'b1;
                win_s          = idx_s;
                o_grant[idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer successor: winner + 1, wrapping at N
    always_comb begin
        if (win_s == PW'(N - 1)) begin
            ptr_d = {PW{1'b0}};
        end else begin
            ptr_d = win_s + PW'(1);
        end
    end

    // Round-robin pointer register, advanced only on a committed grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= {PW{1'b0}};
        end else if ((ARB_MODE == 1) && i_en && found_s) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   N-master to one single-outstanding simple bus. In IDLE the winning request
//   is latched onto the registered bus outputs; in BUSY the bus request is held
//   until i_ack or timeout; RESP lasts one cycle and pulses o_ready (and o_err
//   on timeout) to the owner before returning to IDLE.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_req/i_wr_rd/i_addr/i_wr_data/i_size   per-master request (packed by index)
//   o_ready/o_err                      per-master one-cycle completion / error
//   o_rd_data                          read data broadcast (0 after a timeout)
//   o_grant                            one-hot owner, 0 in IDLE
//   i_ack/i_rd_data                    bus completion and read data
//   o_bus_en/o_wr_rd/o_addr/o_wr_data/o_size   registered bus request
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_MASTERS-1:0]      i_req,
    input  logic [NUM_MASTERS-1:0]      i_wr_rd,
    input  logic [NUM_MASTERS*XLEN-1:0] i_addr,
    input  logic [NUM_MASTERS*XLEN-1:0] i_wr_data,
    input  logic [NUM_MASTERS*3-1:0]    i_size,
    output logic [NUM_MASTERS-1:0]      o_ready,
    output logic [NUM_MASTERS-1:0]      o_err,
    output logic [XLEN-1:0]             o_rd_data,
    output logic [NUM_MASTERS-1:0]      o_grant,
    input  logic                        i_ack,
    input  logic [XLEN-1:0]             i_rd_data,
    output logic                        o_bus_en,
    output logic                        o_wr_rd,
    output logic [XLEN-1:0]             o_addr,
    output logic [XLEN-1:0]             o_wr_data,
    output logic [2:0]                  o_size
);

    localparam int N    = NUM_MASTERS;
    // Counter only needs to reach TIMEOUT; keep at least one bit when disabled
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [N-1:0]    ready_q;
    logic [N-1:0]    err_q;
    logic            bus_en_q;
    logic            wr_rd_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] rd_data_q;
    logic [TO_W-1:0] cnt_q;

    logic [N-1:0]    arb_grant_s;
    logic            arb_en_s;
    logic            timeout_s;
    logic            sel_wr_rd_s;
    logic [XLEN-1:0] sel_addr_s;
    logic [XLEN-1:0] sel_wr_data_s;
    logic [2:0]      sel_size_s;

    // Arbitration is only committed from IDLE; BUSY/RESP never move the pointer
    assign arb_en_s = (state_q == ST_IDLE) && (|i_req);

    rr_arbiter #(
        .N        (N),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_en    (arb_en_s),
        .o_grant (arb_grant_s)
    );

    // One-hot mux of the winner's request fields (AND-OR, grant is one-hot)
    always_comb begin
        sel_wr_rd_s   = 1'b0;
        sel_addr_s    = {XLEN{1'b0}};
        sel_wr_data_s = {XLEN{1'b0}};
        sel_size_s    = 3'b000;
        for (int k = 0; k < N; k++) begin
            sel_wr_rd_s   = sel_wr_rd_s   | (i_wr_rd[k] & arb_grant_s[k]);
            sel_addr_s    = sel_addr_s    | (i_addr[k*XLEN +: XLEN]    & {XLEN{arb_grant_s[k]}});
            sel_wr_data_s = sel_wr_data_s | (i_wr_data[k*XLEN +: XLEN] & {XLEN{arb_grant_s[k]}});
            sel_size_s    = sel_size_s    | (i_size[k*3 +: 3]          & {3{arb_grant_s[k]}});
        end
    end

    // Expiry fires in the TIMEOUT-th BUSY cycle (counter starts at 0)
    always_comb begin
        if (TIMEOUT > 0) begin
            timeout_s = (cnt_q == TO_W'(TIMEOUT - 1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Transfer FSM with registered bus request, response and timeout counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= {N{1'b0}};
            ready_q   <= {N{1'b0}};
            err_q     <= {N{1'b0}};
            bus_en_q  <= 1'b0;
            wr_rd_q   <= 1'b0;
            addr_q    <= {XLEN{1'b0}};
            wr_data_q <= {XLEN{1'b0}};
            size_q    <= 3'b000;
            rd_data_q <= {XLEN{1'b0}};
            cnt_q     <= {TO_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= {N{1'b0}};
                    err_q   <= {N{1'b0}};
                    if (arb_en_s) begin
                        grant_q   <= arb_grant_s;
                        bus_en_q  <= 1'b1;
                        wr_rd_q   <= sel_wr_rd_s;
                        addr_q    <= sel_addr_s;
                        wr_data_q <= sel_wr_data_s;
                        size_q    <= sel_size_s;
                        cnt_q     <= {TO_W{1'b0}};
                        state_q   <= ST_BUSY;
                    end else begin
                        grant_q  <= {N{1'b0}};
                        bus_en_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // An ack coinciding with expiry takes precedence
                    if (i_ack) begin
                        rd_data_q <= i_rd_data;
                        ready_q   <= grant_q;
                        err_q     <= {N{1'b0}};
                        bus_en_q  <= 1'b0;
                        state_q   <= ST_RESP;
                    end else if (timeout_s) begin
                        rd_data_q <= {XLEN{1'b0}};
                        ready_q   <= grant_q;
                        err_q     <= grant_q;
                        bus_en_q  <= 1'b0;
                        state_q   <= ST_RESP;
                    end else if (cnt_q != {TO_W{1'b1}}) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                ST_RESP: begin
                    ready_q <= {N{1'b0}};
                    err_q   <= {N{1'b0}};
                    grant_q <= {N{1'b0}};
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q  <= {N{1'b0}};
                    err_q    <= {N{1'b0}};
                    grant_q  <= {N{1'b0}};
                    bus_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_err     = err_q;
    assign o_rd_data = rd_data_q;
    assign o_grant   = grant_q;
    assign o_bus_en  = bus_en_q;
    assign o_wr_rd   = wr_rd_q;
    assign o_addr    = addr_q;
    assign o_wr_data = wr_data_q;
    assign o_size    = size_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Two 3-master instances share one stimulus: ua (fixed priority) and
//   ub (round-robin), both with TIMEOUT=8. Since both see identical request and
//   ack timing their FSMs stay in step, so either can be observed at any time.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NM  = 3;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] req_s, wr_s;
    logic [NM*32-1:0] addr_s, wdata_s;
    logic [NM*3-1:0]  size_s;
    logic          ack;
    logic [31:0]   bus_rdata;

    logic          mf_req [NM];
    logic          mf_wr  [NM];
    logic [31:0]   mf_addr[NM];
    logic [31:0]   mf_wdata[NM];
    logic [2:0]    mf_size[NM];

    logic [NM-1:0] oa_ready, oa_err, oa_grant, ob_ready, ob_err, ob_grant;
    logic [31:0]   oa_rdata, oa_addr, oa_wdata, ob_rdata, ob_addr, ob_wdata;
    logic          oa_bus_en, oa_wr, ob_bus_en, ob_wr;
    logic [2:0]    oa_size, ob_size;

    logic          sel_b;
    logic [NM-1:0] obs_ready, obs_err, obs_grant;
    logic [31:0]   obs_rdata, obs_addr, obs_wdata;
    logic          obs_bus_en, obs_wr;
    logic [2:0]    obs_size;

    int errs   = 0;
    int checks = 0;
    int rr_ptr = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NM; k++) begin
            req_s[k]             = mf_req[k];
            wr_s[k]              = mf_wr[k];
            addr_s[k*32 +: 32]   = mf_addr[k];
            wdata_s[k*32 +: 32]  = mf_wdata[k];
            size_s[k*3 +: 3]     = mf_size[k];
        end
    end

    always_comb begin
        if (sel_b) begin
            obs_ready = ob_ready; obs_err = ob_err; obs_grant = ob_grant;
            obs_rdata = ob_rdata; obs_addr = ob_addr; obs_wdata = ob_wdata;
            obs_bus_en = ob_bus_en; obs_wr = ob_wr; obs_size = ob_size;
        end else begin
            obs_ready = oa_ready; obs_err = oa_err; obs_grant = oa_grant;
            obs_rdata = oa_rdata; obs_addr = oa_addr; obs_wdata = oa_wdata;
            obs_bus_en = oa_bus_en; obs_wr = oa_wr; obs_size = oa_size;
        end
    end

    bus_arbiter #(.XLEN(32), .NUM_MASTERS(NM), .ARB_MODE(0), .TIMEOUT(TMO)) ua (
        .i_clk(clk), .i_rst(rst), .i_req(req_s), .i_wr_rd(wr_s), .i_addr(addr_s),
        .i_wr_data(wdata_s), .i_size(size_s), .o_ready(oa_ready), .o_err(oa_err),
        .o_rd_data(oa_rdata), .o_grant(oa_grant), .i_ack(ack), .i_rd_data(bus_rdata),
        .o_bus_en(oa_bus_en), .o_wr_rd(oa_wr), .o_addr(oa_addr), .o_wr_data(oa_wdata),
        .o_size(oa_size)
    );

    bus_arbiter #(.XLEN(32), .NUM_MASTERS(NM), .ARB_MODE(1), .TIMEOUT(TMO)) ub (
        .i_clk(clk), .i_rst(rst), .i_req(req_s), .i_wr_rd(wr_s), .i_addr(addr_s),
        .i_wr_data(wdata_s), .i_size(size_s), .o_ready(ob_ready), .o_err(ob_err),
        .o_rd_data(ob_rdata), .o_grant(ob_grant), .i_ack(ack), .i_rd_data(bus_rdata),
        .o_bus_en(ob_bus_en), .o_wr_rd(ob_wr), .o_addr(ob_addr), .o_wr_data(ob_wdata),
        .o_size(ob_size)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] rsize();
        logic [2:0] s;
        case ($urandom % 5)
            0: s = SZ_SB;
            1: s = SZ_SH;
            2: s = SZ_SW;
            3: s = SZ_LBU;
            default: s = SZ_LHU;
        endcase
        return s;
    endfunction

    task automatic clear_masters();
        for (int k = 0; k < NM; k++) begin
            mf_req[k] = 1'b0; mf_wr[k] = 1'b0; mf_addr[k] = 32'h0;
            mf_wdata[k] = 32'h0; mf_size[k] = 3'b000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack = 1'b0;
        clear_masters();
        tick();
        tick();
        rst = 1'b0;
        rr_ptr = 0;
    endtask

    // Called in an IDLE cycle with the winner w expected at the next edge.
    // Ack arrives in BUSY cycle dly (dly >= TMO means the bus never answers).
    task automatic run_xfer(input int w, input int dly, input bit drop_mid,
                            input bit drop_owner, input logic [31:0] rdat, input string tag);
        logic [31:0]   ea, ed;
        logic          ew;
        logic [2:0]    es;
        logic [NM-1:0] oh;
        bit            tmo;
        int            nb;
        oh  = 3'b001 << w;
        ea  = mf_addr[w]; ed = mf_wdata[w]; ew = mf_wr[w]; es = mf_size[w];
        tmo = (dly >= TMO);
        nb  = tmo ? TMO : dly + 1;
        tick();
        for (int i = 0; i < nb; i++) begin
            chk({tag, " grant"}, obs_grant, oh);
            chk({tag, " bus_en"}, obs_bus_en, 1'b1);
            chk({tag, " addr"}, obs_addr, ea);
            chk({tag, " wdata"}, obs_wdata, ed);
            chk({tag, " wr_rd"}, obs_wr, ew);
            chk({tag, " size"}, obs_size, es);
            chk({tag, " ready_busy"}, obs_ready, 3'b000);
            ack       = (i == dly);
            bus_rdata = (i == dly) ? rdat : $urandom;
            mf_addr[w]  = $urandom;
            mf_wdata[w] = $urandom;
            if (drop_mid) mf_req[w] = 1'b0;
            tick();
        end
        ack = 1'b0;
        chk({tag, " ready"}, obs_ready, oh);
        chk({tag, " err"}, obs_err, tmo ? oh : 3'b000);
        chk({tag, " bus_en_resp"}, obs_bus_en, 1'b0);
        if (!ew) chk({tag, " rd_data"}, obs_rdata, tmo ? 32'h0 : rdat);
        if (drop_owner) mf_req[w] = 1'b0;
        ack = 1'($urandom % 2);
        tick();
        ack = 1'b0;
        chk({tag, " ready_pulse"}, obs_ready, 3'b000);
        chk({tag, " err_pulse"}, obs_err, 3'b000);
        chk({tag, " grant_idle"}, obs_grant, 3'b000);
        chk({tag, " bus_en_idle"}, obs_bus_en, 1'b0);
    endtask

    // Reference winner: lowest pending index, or first pending from rr_ptr
    function automatic int model_winner(input bit rr);
        for (int i = 0; i < NM; i++) begin
            int j;
            j = rr ? (rr_ptr + i) % NM : i;
            if (mf_req[j]) return j;
        end
        return -1;
    endfunction

    task automatic rand_phase(input bit rr, input int n, input string tag);
        int w;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < NM; k++) begin
                if (!mf_req[k] && ($urandom % 2 == 0)) begin
                    mf_req[k] = 1'b1; mf_wr[k] = 1'($urandom % 2);
                    mf_addr[k] = $urandom; mf_wdata[k] = $urandom; mf_size[k] = rsize();
                end
            end
            w = model_winner(rr);
            if (w < 0) begin
                ack = 1'($urandom % 2);
                tick();
                ack = 1'b0;
                chk({tag, " idle_grant"}, obs_grant, 3'b000);
                chk({tag, " idle_bus_en"}, obs_bus_en, 1'b0);
            end else begin
                run_xfer(w, $urandom_range(0, 10), ($urandom % 4) == 0, 1'b1, $urandom, tag);
                if (rr) rr_ptr = (w + 1) % NM;
            end
        end
        clear_masters();
    endtask

    typedef struct {
        logic [NM-1:0] req;
        int            dly;
        int            win;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'b001, 0, 0};
        vecs[1] = '{3'b010, 1, 1};
        vecs[2] = '{3'b100, 2, 2};
        vecs[3] = '{3'b011, 3, 0};
        vecs[4] = '{3'b110, 7, 1};
        vecs[5] = '{3'b101, 8, 0};
        vecs[6] = '{3'b111, 10, 0};
        vecs[7] = '{3'b000, 0, -1};
        vecs[8] = '{3'b100, 9, 2};

        sel_b = 1'b0;
        bus_rdata = 32'h0;
        rst = 1'b1;
        ack = 1'b0;
        clear_masters();
        tick();
        chk("rst bus_en", oa_bus_en, 1'b0);
        chk("rst grant", {oa_grant, ob_grant}, 6'b0);
        chk("rst ready", {oa_ready, ob_ready, oa_err, ob_err}, 12'b0);
        chk("rst bus", {oa_addr, oa_wdata}, 64'h0);
        chk("rst rdata", {oa_rdata, oa_wr, oa_size}, 36'h0);
        do_reset();

        // Single read from M0, ack three cycles after the request
        mf_req[0] = 1'b1; mf_wr[0] = DIR_READ; mf_addr[0] = 32'h100; mf_size[0] = SZ_SW;
        run_xfer(0, 2, 1'b0, 1'b1, 32'hDEADBEEF, "t1");

        // Fixed priority: M0 keeps winning while it holds i_req
        mf_req[0] = 1'b1; mf_req[1] = 1'b1; mf_wr[1] = DIR_WRITE; mf_addr[1] = 32'h300;
        run_xfer(0, 0, 1'b0, 1'b0, $urandom, "t2 m0a");
        run_xfer(0, 1, 1'b0, 1'b0, $urandom, "t2 m0b");
        run_xfer(0, 0, 1'b0, 1'b1, $urandom, "t2 m0c");
        run_xfer(1, 0, 1'b0, 1'b1, $urandom, "t2 m1");
        clear_masters();

        // Table of request patterns / ack delays on the fixed-priority arbiter
        foreach (vecs[v]) begin
            for (int k = 0; k < NM; k++) begin
                mf_req[k] = vecs[v].req[k]; mf_wr[k] = 1'($urandom % 2);
                mf_addr[k] = $urandom; mf_wdata[k] = $urandom; mf_size[k] = rsize();
            end
            if (vecs[v].win < 0) begin
                tick();
                chk($sformatf("tbl%0d grant", v), obs_grant, 3'b000);
                chk($sformatf("tbl%0d bus_en", v), obs_bus_en, 1'b0);
            end else begin
                run_xfer(vecs[v].win, vecs[v].dly, 1'b0, 1'b1, $urandom, $sformatf("tbl%0d", v));
            end
            clear_masters();
        end

        // Timeout: no ack at all, then an ack exactly in the expiry cycle
        mf_req[2] = 1'b1; mf_wr[2] = DIR_READ; mf_addr[2] = 32'h400;
        run_xfer(2, 100, 1'b0, 1'b1, 32'h12345678, "t4 tmo");
        mf_req[2] = 1'b1;
        run_xfer(2, TMO - 1, 1'b0, 1'b1, 32'hCAFEF00D, "t4 edge");

        // Write from M1; its address/data inputs change every BUSY cycle
        mf_req[1] = 1'b1; mf_wr[1] = DIR_WRITE; mf_addr[1] = 32'h2000;
        mf_wdata[1] = 32'h55; mf_size[1] = SZ_SB;
        run_xfer(1, 4, 1'b0, 1'b1, $urandom, "t5");

        // Asynchronous reset in the middle of a transfer
        mf_req[0] = 1'b1; mf_addr[0] = 32'h500;
        tick();
        chk("t6 busy", obs_bus_en, 1'b1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("t6 rst bus_en", obs_bus_en, 1'b0);
        chk("t6 rst grant", obs_grant, 3'b000);
        chk("t6 rst addr", obs_addr, 32'h0);
        mf_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6 late ack ready", obs_ready, 3'b000);
            chk("t6 late ack err", obs_err, 3'b000);
            chk("t6 late ack bus_en", obs_bus_en, 1'b0);
        end
        ack = 1'b0;
        mf_req[2] = 1'b1; mf_wr[2] = DIR_READ; mf_addr[2] = 32'h600; mf_size[2] = SZ_LHU;
        run_xfer(2, 1, 1'b0, 1'b1, 32'h0BADCAFE, "t6 after");

        rand_phase(1'b0, 40, "rnd fix");

        // Round-robin instance from a fresh reset
        do_reset();
        sel_b = 1'b1;
        for (int k = 0; k < NM; k++) begin
            mf_req[k] = 1'b1; mf_addr[k] = 32'h1000 * (k + 1); mf_size[k] = SZ_SW;
        end
        for (int r = 0; r < 6; r++) begin
            run_xfer(r % NM, 0, 1'b0, 1'b0, $urandom, $sformatf("t3 rr%0d", r));
            rr_ptr = (r % NM + 1) % NM;
        end
        clear_masters();
        tick();

        rand_phase(1'b1, 40, "rnd rr");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
